// File: rtl/leading_zero_insert.sv
`default_nettype none
// ============================================================================
//  Module   : leading_zero_insert
//  Purpose  : Multi-cycle logical right shifter that undoes a normalisation.
//             An MSB-aligned operand and a zero count k are accepted, and the
//             operand is returned with min(k, N) zeros reinserted at the top.
//             A sticky bit collects the OR of every bit shifted out, for use
//             by downstream rounding.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LG_N     log2 of the data width, N = 1 << LG_N
//    LG_STEP  log2 of the largest shift applied per cycle (0..LG_N)
//
//  Ports
//    clk         in   1        clock, all state changes on the rising edge
//    reset       in   1        synchronous, active-high reset
//    in_valid    in   1        request valid
//    in_ready    out  1        block can accept a request (IDLE)
//    in_x        in   N        value to shift
//    in_k        in   LG_N+1   zero count; values above N act as N
//    out_valid   out  1        result valid (DONE)
//    out_ready   in   1        consumer accepts the result
//    out_y       out  N        in_x >> min(in_k, N)
//    out_sticky  out  1        OR of all bits shifted out of out_y
//    busy        out  1        block is not IDLE
//
//  Build option
//    LEADING_ZERO_INSERT_FASTPATH_EN  when defined, a clamped count equal to N
//    bypasses the shift loop and completes in one cycle. Results are the same
//    in both builds; only the latency of full-flush requests changes.
// ============================================================================

module leading_zero_insert #(
  parameter int LG_N    = 6,
  parameter int LG_STEP = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(1<<LG_N)-1:0]   in_x,
  input  logic [LG_N:0]          in_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<LG_N)-1:0]   out_y,
  output logic                   out_sticky,
  output logic                   busy
);

  localparam int N = 1 << LG_N;

  // Shift-count constants at the width of the remaining-count register so
  // every comparison below is width-matched.
  localparam logic [LG_N:0]  C_N    = (LG_N+1)'(1 << LG_N);
  localparam logic [LG_N:0]  C_STEP = (LG_N+1)'(1 << LG_STEP);
  localparam logic [N-1:0]   C_ONES = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    data_q,  data_d;
  logic [LG_N:0]   rem_q,   rem_d;
  logic            sticky_q, sticky_d;

  logic [LG_N:0]   w_k_clamp;
  logic [LG_N:0]   w_amt;
  logic [LG_N:0]   w_rem_left;
  logic [N-1:0]    w_lost;

  // The clamp looks at the whole in_k field, so counts between N+1 and
  // 2N-1 saturate to N rather than wrapping.
  assign w_k_clamp = (in_k > C_N) ? C_N : in_k;

  // Per-cycle shift distance and the bits that fall off the bottom. The mask
  // is built by shifting an all-ones word, which stays correct even when
  // STEP equals N (shift by the full width yields zero).
  assign w_amt      = (rem_q < C_STEP) ? rem_q : C_STEP;
  assign w_rem_left = rem_q - w_amt;
  assign w_lost     = data_q & ~(C_ONES << w_amt);

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d   = in_x;
          rem_d    = w_k_clamp;
          sticky_d = 1'b0;
          state_d  = (w_k_clamp == '0) ? S_DONE : S_SHIFT;
`ifdef LEADING_ZERO_INSERT_FASTPATH_EN
          // Full flush: every input bit is shifted out, so the answer is
          // known immediately without iterating.
          if (w_k_clamp == C_N) begin
            data_d   = '0;
            sticky_d = |in_x;
            rem_d    = '0;
            state_d  = S_DONE;
          end
`endif
        end
      end

      S_SHIFT: begin
        data_d   = data_q >> w_amt;
        sticky_d = sticky_q | (|w_lost);
        rem_d    = w_rem_left;
        if (w_rem_left == '0) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Handoff returns to IDLE; no new request is taken this same cycle.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The result bus is zero outside DONE so intermediate shift
  // values never appear on it.
  // --------------------------------------------------------------------------
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_y      = out_valid ? data_q : '0;
  assign out_sticky = out_valid & sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_leading_zero_insert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leading_zero_insert
//  Purpose  : Self-checking bench for leading_zero_insert. Directed cases for
//             latency, backpressure and reset, then randomized requests
//             compared with an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_leading_zero_insert;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [6:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_y;
  logic        out_sticky;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  leading_zero_insert #(.LG_N(6), .LG_STEP(3)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_k       (in_k),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_sticky (out_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_k(input int k);
    return (k > N) ? N : k;
  endfunction

  function automatic int exp_latency(input int k);
    int kc;
    kc = clamp_k(k);
    if (kc == 0) return 1;
`ifdef LEADING_ZERO_INSERT_FASTPATH_EN
    if (kc == N) return 1;
`endif
    return 1 + (kc + 7) / 8;
  endfunction

  function automatic logic [63:0] ref_y(input logic [63:0] x, input int k);
    if (clamp_k(k) >= N) return 64'd0;
    return x >> k;
  endfunction

  function automatic logic ref_sticky(input logic [63:0] x, input int k);
    logic [63:0] lost;
    int kc;
    kc = clamp_k(k);
    if (kc >= N) return |x;
    if (kc == 0) return 1'b0;
    lost = x << (N - kc);  // the kc low bits moved to the top
    return |lost;
  endfunction

  function automatic int clz(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) return 63 - i;
    end
    return 64;
  endfunction

  // One complete request with out_ready held high.
  task automatic run_req(input logic [63:0] x, input int k, input string tag,
                         input bit do_clz);
    int lat;
    @(negedge clk);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_x      = x;
    in_k      = 7'(k);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = {$urandom, $urandom};
    in_k     = 7'($urandom_range(0, 127));
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_latency(k)));
    check({tag, "/busy"}, 64'(busy), 64'd1);
    check({tag, "/y"}, out_y, ref_y(x, k));
    check({tag, "/sticky"}, 64'(out_sticky), 64'(ref_sticky(x, k)));
    if (do_clz) check({tag, "/clz"}, 64'(clz(out_y)), 64'(k));
    @(negedge clk);
    check({tag, "/idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held_y;
    logic        held_s;
    int          cyc;
    logic [63:0] rx;
    int          rk;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_k      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/out_y", out_y, 64'd0);
    check("reset/sticky", 64'(out_sticky), 64'd0);
    reset = 1'b0;

    // ---------------- directed cases ----------------
    // busy must be high in the cycle right after the accept as well
    @(negedge clk);
    in_valid = 1'b1; in_x = 64'h8000_0000_0000_0000; in_k = 7'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("k3/busy_c1", 64'(busy), 64'd1);
    check("k3/valid_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("k3/valid_c2", 64'(out_valid), 64'd1);
    check("k3/busy_c2", 64'(busy), 64'd1);
    check("k3/y", out_y, 64'h1000_0000_0000_0000);
    check("k3/sticky", 64'(out_sticky), 64'd0);
    @(negedge clk);
    check("k3/idle", 64'(in_ready), 64'd1);

    run_req(64'h8000_0000_0000_0000, 3,   "single", 1'b1);
    run_req(64'hFFFF_0000_0000_00FF, 20,  "multi",  1'b0);
    run_req(64'h0000_0000_0000_1234, 0,   "k0",     1'b0);
    run_req(64'h0000_0000_0000_0001, 100, "k100",   1'b0);
    run_req(64'hDEAD_BEEF_0000_0001, 64,  "k64",    1'b0);
    run_req(64'h8000_0000_0000_00FF, 8,   "k8",     1'b1);
    run_req(64'hFFFF_FFFF_FFFF_FFFF, 127, "k127",   1'b0);
    run_req(64'h8000_0000_0000_0000, 63,  "k63",    1'b1);

    // ---------------- backpressure ----------------
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_x = 64'hF0F0_0000_0000_000F; in_k = 7'd12;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp/valid", 64'(out_valid), 64'd1);
    check("bp/y", out_y, 64'h000F_0F00_0000_0000);
    check("bp/sticky", 64'(out_sticky), 64'd1);
    held_y = out_y;
    held_s = out_sticky;
    // a competing request while DONE must be ignored
    in_valid = 1'b1; in_x = 64'h1; in_k = 7'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp/hold_valid", 64'(out_valid), 64'd1);
      check("bp/hold_y", out_y, held_y);
      check("bp/hold_sticky", 64'(out_sticky), 64'(held_s));
      check("bp/hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp/after_ready", 64'(in_ready), 64'd1);
    check("bp/after_valid", 64'(out_valid), 64'd0);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    in_valid = 1'b1; in_x = 64'hFFFF_FFFF_FFFF_FFFF; in_k = 7'd40;
    @(negedge clk);               // cycle 1
    in_valid = 1'b0;
    @(negedge clk);               // cycle 2
    reset = 1'b1;
    @(negedge clk);               // cycle 3
    reset = 1'b0;
    check("rst/in_ready", 64'(in_ready), 64'd1);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_y", out_y, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst/no_valid", 64'(out_valid), 64'd0);
    end
    run_req(64'hC000_0000_0000_0003, 40, "post_rst", 1'b0);

    // reset and in_valid together: nothing captured
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_x = 64'h5; in_k = 7'd5;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rst_valid/busy", 64'(busy), 64'd0);
    check("rst_valid/in_ready", 64'(in_ready), 64'd1);

    // ---------------- randomized ----------------
    for (int i = 0; i < 2000; i++) begin
      rx = {1'b1, 31'($urandom), $urandom};
      rk = $urandom_range(0, 63);
      run_req(rx, rk, "rand_norm", 1'b1);
    end
    for (int i = 0; i < 500; i++) begin
      rx = {$urandom, $urandom};
      rk = $urandom_range(0, 127);
      run_req(rx, rk, "rand_any", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
